// File: rtl/tsmac_gmii_tx_fifo_reader.sv
// GMII transmit reader: pops {err,eof,byte} words from the TX FIFO, adds preamble/SFD,
// enforces the inter-packet gap and aborts frames on underflow or jabber with tx_er.
module tsmac_gmii_tx_fifo_reader #(
  parameter int unsigned IpgCycles = 12,
  parameter int unsigned MaxFrame  = 1522,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [9:0]          rd_data_i,
  input  logic                rd_empty_i,
  output logic                rd_en_o,
  output logic [7:0]          txd_o,
  output logic                tx_en_o,
  output logic                tx_er_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                underflow_err_o,
  output logic                jabber_err_o,
  output logic [CntWidth-1:0] frame_cnt_o
);

  localparam int unsigned ByteCntW = $clog2(MaxFrame + 1);
  localparam int unsigned IpgCntW  = $clog2(IpgCycles + 1);
  localparam logic [ByteCntW-1:0] MaxFrameW = ByteCntW'(MaxFrame);
  localparam logic [IpgCntW-1:0]  IpgLastW  = IpgCntW'(IpgCycles);

  typedef enum logic [2:0] {StIdle, StPre, StData, StAbort, StIpg} state_e;

  state_e                state_q, state_d;
  logic [2:0]            pre_cnt_q, pre_cnt_d;
  logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [IpgCntW-1:0]    ipg_cnt_q, ipg_cnt_d;
  logic                  rd_en_q;
  logic [7:0]            txd_q, txd_d;
  logic                  tx_en_q, tx_en_d;
  logic                  tx_er_q, tx_er_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underflow_q, underflow_d;
  logic                  jabber_q, jabber_d;
  logic [CntWidth-1:0]   frame_cnt_q, frame_cnt_d;
  logic                  rd_pop;
  logic                  eof_seen;

  assign eof_seen     = rd_en_q && rd_data_i[8];
  assign byte_cnt_inc = byte_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    ipg_cnt_d    = ipg_cnt_q;
    txd_d        = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    underflow_d  = 1'b0;
    jabber_d     = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    rd_pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rd_empty_i) begin
          state_d    = StPre;
          txd_d      = 8'h55;
          tx_en_d    = 1'b1;
          pre_cnt_d  = 3'd1;
          byte_cnt_d = '0;
        end
      end
      StPre: begin
        tx_en_d   = 1'b1;
        pre_cnt_d = pre_cnt_q + 3'd1;
        if (pre_cnt_q == 3'd7) begin
          // First pop lands on rd_data while the SFD is on the wire.
          txd_d   = 8'hD5;
          rd_pop  = !rd_empty_i;
          state_d = StData;
        end else begin
          txd_d = 8'h55;
        end
      end
      StData: begin
        rd_pop  = !rd_empty_i && !eof_seen;
        tx_en_d = 1'b1;
        if (rd_en_q) begin
          txd_d      = rd_data_i[7:0];
          byte_cnt_d = byte_cnt_inc;
          if (rd_data_i[8]) begin
            tx_er_d      = rd_data_i[9];
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            ipg_cnt_d    = '0;
            state_d      = StIpg;
          end else if (byte_cnt_inc == MaxFrameW) begin
            tx_er_d  = 1'b1;
            jabber_d = 1'b1;
            state_d  = StAbort;
          end else begin
            tx_er_d = rd_data_i[9];
          end
        end else begin
          tx_er_d     = 1'b1;
          underflow_d = 1'b1;
          state_d     = StAbort;
        end
      end
      StAbort: begin
        if (eof_seen) begin
          // tx_en is already low here, so this cycle counts as the first gap cycle.
          ipg_cnt_d = IpgCntW'(1);
          state_d   = StIpg;
        end else begin
          rd_pop = !rd_empty_i;
        end
      end
      StIpg: begin
        if (ipg_cnt_q == IpgLastW) begin
          state_d = StIdle;
        end else begin
          ipg_cnt_d = ipg_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_en_o = rd_pop && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pre_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      ipg_cnt_q    <= '0;
      rd_en_q      <= 1'b0;
      txd_q        <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      jabber_q     <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      ipg_cnt_q    <= ipg_cnt_d;
      rd_en_q      <= rd_en_o;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
      jabber_q     <= jabber_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign txd_o           = txd_q;
  assign tx_en_o         = tx_en_q;
  assign tx_er_o         = tx_er_q;
  assign busy_o          = (state_q != StIdle);
  assign frame_done_o    = frame_done_q;
  assign underflow_err_o = underflow_q;
  assign jabber_err_o    = jabber_q;
  assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_tsmac_gmii_tx_fifo_reader.sv
// Scoreboard bench: frame-level model predicts every tx_en cycle; a negedge monitor checks them.
module tb_tsmac_gmii_tx_fifo_reader;

  localparam int unsigned Ipg  = 12;
  localparam int unsigned MaxF = 64;
  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [9:0]      rd_data = '0;
  logic            rd_empty = 1'b1;
  logic            rd_en;
  logic [7:0]      txd;
  logic            tx_en, tx_er, busy, frame_done, underflow_err, jabber_err;
  logic [CntW-1:0] frame_cnt;

  tsmac_gmii_tx_fifo_reader #(
    .IpgCycles(Ipg),
    .MaxFrame (MaxF),
    .CntWidth (CntW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rd_data_i      (rd_data),
    .rd_empty_i     (rd_empty),
    .rd_en_o        (rd_en),
    .txd_o          (txd),
    .tx_en_o        (tx_en),
    .tx_er_o        (tx_er),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .underflow_err_o(underflow_err),
    .jabber_err_o   (jabber_err),
    .frame_cnt_o    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      d;
    logic            er, fd, uf, jb;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [9:0] fifo[$];
  logic [9:0] pend[$];
  logic [9:0] wq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         model_cnt = 0;
  bit         rd_en_snap = 1'b0;
  int         gap = 0;
  int         last_gap = -1;
  bit         gap_valid = 1'b0;
  bit         prev_en = 1'b0;

  // FIFO model: rd_en seen before the edge pops a word that appears just after it.
  always @(negedge clk) rd_en_snap = rd_en;

  initial forever begin
    @(posedge clk);
    #1;
    if (rd_en_snap) begin
      n_cmp++;
      if (fifo.size() == 0) begin
        n_err++;
        $display("FAIL pop_on_empty: got rd_en=1 with empty fifo, want rd_en=0");
      end else begin
        rd_data = fifo.pop_front();
      end
    end
    while (pend.size() != 0) fifo.push_back(pend.pop_front());
    rd_empty = (fifo.size() == 0);
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_en) begin
        if (!prev_en) begin
          if (gap_valid) begin
            n_cmp++;
            if (gap < int'(Ipg) + 1) begin
              n_err++;
              $display("FAIL ipg_min: got gap=%0d, want >=%0d", gap, Ipg + 1);
            end
          end
          last_gap = gap;
        end
        gap = 0;
        prev_en = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_tx: got txd=%h tx_en=1, want tx_en=0", txd);
        end else begin
          e = exp_q.pop_front();
          if (txd !== e.d || tx_er !== e.er || frame_done !== e.fd ||
              underflow_err !== e.uf || jabber_err !== e.jb || frame_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL tx_cycle: got d=%h er=%b fd=%b uf=%b jb=%b cnt=%0d, want d=%h er=%b fd=%b uf=%b jb=%b cnt=%0d",
                     txd, tx_er, frame_done, underflow_err, jabber_err, frame_cnt,
                     e.d, e.er, e.fd, e.uf, e.jb, e.cnt);
          end
        end
      end else begin
        if (prev_en) gap_valid = 1'b1;
        prev_en = 1'b0;
        gap++;
        n_cmp++;
        if (txd !== 8'h00 || tx_er !== 1'b0 || frame_done !== 1'b0 ||
            underflow_err !== 1'b0 || jabber_err !== 1'b0) begin
          n_err++;
          $display("FAIL idle_outputs: got d=%h er=%b fd=%b uf=%b jb=%b, want all zero",
                   txd, tx_er, frame_done, underflow_err, jabber_err);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic er, fd, uf, jb);
    exp_t x;
    x.d = d; x.er = er; x.fd = fd; x.uf = uf; x.jb = jb; x.cnt = CntW'(model_cnt);
    exp_q.push_back(x);
  endtask

  // Reference: what one frame looks like on GMII, given all of its words are queued at once.
  task automatic send(input logic [9:0] w[$]);
    bit done = 1'b0;
    for (int i = 0; i < 7; i++) add(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8'hD5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < w.size(); i++) begin
      if (!done) begin
        if (w[i][8]) begin
          model_cnt++;
          add(w[i][7:0], w[i][9], 1'b1, 1'b0, 1'b0);
          done = 1'b1;
        end else if (i + 1 == int'(MaxF)) begin
          add(w[i][7:0], 1'b1, 1'b0, 1'b0, 1'b1);
          done = 1'b1;
        end else begin
          add(w[i][7:0], w[i][9], 1'b0, 1'b0, 1'b0);
          if (i == w.size() - 1) add(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        end
      end
    end
    foreach (w[i]) pend.push_back(w[i]);
  endtask

  task automatic mk_frame(input int len);
    wq.delete();
    for (int i = 0; i < len; i++) begin
      logic [9:0] v;
      v[7:0] = 8'($urandom);
      v[9]   = ($urandom_range(0, 15) == 0);
      v[8]   = (i == len - 1);
      wq.push_back(v);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || fifo.size() != 0 || pend.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy || fifo.size() != 0 || pend.size() != 0) begin
      n_err++;
      $display("FAIL wait_idle_timeout: got busy=%b exp_left=%0d fifo=%0d, want idle",
               busy, exp_q.size(), fifo.size());
    end
  endtask

  task automatic wait_exp(input int left, input int budget);
    int k = 0;
    while (exp_q.size() > left && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() > left) begin
      n_err++;
      $display("FAIL wait_exp_timeout: got exp_left=%0d, want <=%0d", exp_q.size(), left);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_txd", 32'(txd), 0);
    check("rst_tx_er", 32'(tx_er), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_flags", {29'd0, frame_done, underflow_err, jabber_err}, 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    tick();

    // Basic 4-byte frame plus preamble/pop timing
    wq.delete();
    wq.push_back(10'h011); wq.push_back(10'h022); wq.push_back(10'h033); wq.push_back(10'h144);
    send(wq);
    tick();
    check("idle_decision_tx_en", 32'(tx_en), 0);
    tick();
    check("first_pre_tx_en", 32'(tx_en), 1);
    check("first_pre_txd", 32'(txd), 32'h55);
    tick(5);
    check("rd_en_6th_pre", 32'(rd_en), 0);
    tick();
    check("rd_en_7th_pre", 32'(rd_en), 1);
    tick();
    check("sfd_txd", 32'(txd), 32'hD5);
    wait_idle(200);
    check("t1_frame_cnt", 32'(frame_cnt), 1);

    // Back-to-back 60-byte frames: minimum gap
    mk_frame(60);
    send(wq);
    mk_frame(60);
    send(wq);
    wait_idle(400);
    check("b2b_gap", 32'(last_gap), Ipg + 1);

    // Underflow after 10 bytes, then late eof words discarded
    wq.delete();
    for (int i = 0; i < 10; i++) wq.push_back({2'b00, 8'(8'hA0 + i)});
    send(wq);
    wait_exp(0, 200);
    tick(5);
    check("abort_busy", 32'(busy), 1);
    check("abort_tx_en", 32'(tx_en), 0);
    pend.push_back(10'h0C1);
    pend.push_back(10'h1C2);
    wait_idle(200);
    check("uf_frame_cnt", 32'(frame_cnt), 32'(model_cnt));

    // Jabber: 70-byte frame aborted at byte 64, then legal 64-byte frame
    mk_frame(70);
    send(wq);
    wait_idle(400);
    mk_frame(64);
    send(wq);
    wait_idle(400);
    check("jab_frame_cnt", 32'(frame_cnt), 32'(model_cnt));

    // Error byte mid-frame
    wq.delete();
    for (int i = 0; i < 7; i++) wq.push_back(10'h010 + 10'(i));
    wq[3] = 10'h2AB;
    wq.push_back(10'h1EE);
    send(wq);
    wait_idle(200);

    // Random frames, some queued while the previous one is still going
    for (int f = 0; f < 24; f++) begin
      mk_frame(int'($urandom_range(1, 72)));
      send(wq);
      if ($urandom_range(0, 1) == 0) wait_idle(600);
      else tick(int'($urandom_range(0, 30)));
    end
    wait_idle(4000);
    check("rand_frame_cnt", 32'(frame_cnt), 32'(model_cnt));

    // Reset mid-frame
    mk_frame(30);
    send(wq);
    wait_exp(20, 200);
    rst = 1'b1;
    fifo.delete();
    pend.delete();
    rd_empty = 1'b1;
    tick();
    check("mid_rst_tx_en", 32'(tx_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    exp_q.delete();
    model_cnt = 0;
    gap_valid = 1'b0;
    prev_en = 1'b0;
    gap = 0;
    rst = 1'b0;
    tick(2);
    mk_frame(5);
    send(wq);
    wait_idle(200);
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
